// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-at-a-time word fetches,
// buffers one returned word and drives the registered fetch/decode boundary.
module if_fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        memory_stall,
  input  logic        branch_taken,
  input  logic [5:0]  branch_offset_imm,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic        instruction_decode_en,
  output logic [15:0] pc_out,
  output logic [1:0]  fsm_state
);

  // Fetch handshake: imem_req holds high with imem_addr stable until the
  // single-cycle imem_ack pulse; the word in imem_rdata is taken on that edge.
  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_FETCH   = 2'd1,
    S_FULL    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] fetch_pc;
  logic [15:0] hold_addr;
  logic [15:0] buf_instr;
  logic [15:0] buf_pc;
  logic        buf_valid;
  logic        buf_valid_nxt;
  logic        adv;
  logic        redirect;
  logic        ack_ok;
  logic        bypass;
  logic [15:0] target;

  assign adv      = ~stall & ~memory_stall;
  assign redirect = branch_taken & adv;
  assign target   = pc_out + 16'd1 + {{10{branch_offset_imm[5]}}, branch_offset_imm};
  // Acks seen in DISCARD, or colliding with a redirect, are dropped.
  assign ack_ok   = imem_ack & (state == S_FETCH) & ~redirect;
  assign bypass   = ack_ok & adv & ~buf_valid;

  always_comb begin
    buf_valid_nxt = buf_valid;
    if (redirect) begin
      buf_valid_nxt = 1'b0;
    end else begin
      if (adv && buf_valid) buf_valid_nxt = 1'b0;
      if (ack_ok && !bypass) buf_valid_nxt = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RESET;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RESET:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (redirect)    state_nxt = imem_ack ? S_FETCH : S_DISCARD;
        else if (ack_ok) state_nxt = buf_valid_nxt ? S_FULL : S_FETCH;
      end
      S_FULL:    if (!buf_valid_nxt) state_nxt = S_FETCH;
      S_DISCARD: if (imem_ack) state_nxt = S_FETCH;
      default:   state_nxt = S_RESET;
    endcase
  end

  // Output decode of the state register
  always_comb begin
    imem_req  = (state == S_FETCH) || (state == S_DISCARD);
    imem_addr = (state == S_DISCARD) ? hold_addr : fetch_pc;
    fsm_state = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc              <= 16'h0000;
      hold_addr             <= 16'h0000;
      buf_valid             <= 1'b0;
      buf_instr             <= 16'h0000;
      buf_pc                <= 16'h0000;
      instruction           <= 16'h0000;
      instruction_decode_en <= 1'b0;
      pc_out                <= 16'h0000;
    end else begin
      buf_valid <= buf_valid_nxt;
      if (ack_ok && !bypass) begin
        buf_instr <= imem_rdata;
        buf_pc    <= fetch_pc;
      end
      if (redirect)    fetch_pc <= target;
      else if (ack_ok) fetch_pc <= fetch_pc + 16'd1;
      // Keep the in-flight address on the bus while its stale reply drains.
      if ((state == S_FETCH) && redirect && !imem_ack) hold_addr <= fetch_pc;
      if (adv) begin
        if (redirect) begin
          instruction           <= 16'h0000;
          instruction_decode_en <= 1'b0;
        end else if (buf_valid) begin
          instruction           <= buf_instr;
          instruction_decode_en <= 1'b1;
          pc_out                <= buf_pc;
        end else if (ack_ok) begin
          instruction           <= imem_rdata;
          instruction_decode_en <= 1'b1;
          pc_out                <= fetch_pc;
        end else begin
          instruction           <= 16'h0000;
          instruction_decode_en <= 1'b0;
        end
      end
    end
  end

endmodule
